load_store_unit: RTL and testbench

Memory-stage controller between the pipeline's execute stage and Data_Memory. It accepts one load/store request at a time over a valid/ready handshake and translates byte addresses into word accesses. It drives the memory's write-enable, read-enable, address and write-data pins, registers the returned word, and hands a single response back upstream. Sub-word stores are performed as read-modify-write.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_lane.sv | 61 ++++++
 rtl/load_store_unit.sv | 157 +++++++++++++++
 tb/tb_load_store_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared encodings, FSM states and alignment check for the load/store unit
//
// Purpose : access-size encodings, controller state type and the alignment
//           rule used when a request is accepted.
// Ports   : none (package).

package lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_READ  = 2'b01,
        ST_WRITE = 2'b10,
        ST_RESP  = 2'b11
    } lsu_state_t;

    // Halves need an even address, words a multiple of four; bytes are never
    // misaligned. The reserved size is rejected separately by the caller.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_HALF: return lane[0];
            SZ_WORD: return (lane != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// rtl/lsu_lane.sv - byte-lane extract/extend for loads and lane merge for stores
//
// Purpose : purely combinational lane logic, fed with the memory word during
//           READ and with the captured word during WRITE.
// Ports   : word      in  32  source word (memory data or captured word)
//           lane      in  2   byte address bits [1:0]
//           size      in  2   access size encoding
//           sign_ext  in  1   sign-extend sub-word loads
//           wdata     in  32  right-aligned store data
//           load_data out 32  extracted and extended load result
//           merged    out 32  word with the addressed lane(s) replaced by wdata

module lsu_lane
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;
    logic [31:0] mask;
    logic [31:0] ins;

    always_comb begin
        // Little-endian: lane 0 is bits [7:0]; halves use lane[1] only.
        byte_val = 8'(word >> {lane, 3'b000});
        half_val = 16'(word >> {lane[1], 4'b0000});

        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & byte_val[7]}}, byte_val};
            SZ_HALF: load_data = {{16{sign_ext & half_val[15]}}, half_val};
            default: load_data = word;
        endcase

        // Store data is replicated across all lanes so the mask alone picks
        // where it lands.
        case (size)
            SZ_BYTE: begin
                mask = 32'h0000_00FF << {lane, 3'b000};
                ins  = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                mask = 32'h0000_FFFF << {lane[1], 4'b0000};
                ins  = {2{wdata[15:0]}};
            end
            default: begin
                mask = 32'hFFFF_FFFF;
                ins  = wdata;
            end
        endcase

        merged = (word & ~mask) | (ins & mask);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-stage load/store controller in front of Data_Memory
//
// Purpose : accepts one load/store at a time, converts byte addresses into
//           word accesses, performs sub-word stores as read-modify-write and
//           returns a single response.
// Config  : RMW_SUBWORD_EN defined   -> byte/half stores do READ then WRITE merge.
//           RMW_SUBWORD_EN undefined -> byte/half stores answer rsp_err=1.
// Ports   : clk, rst (async, active high)
//           req_valid/req_ready, req_we, req_size, req_signed, req_addr[9:0],
//           req_wdata[31:0]                     request channel
//           rsp_valid/rsp_ready, rsp_rdata[31:0], rsp_err   response channel
//           mem_wr, mem_rd, mem_addr[7:0], mem_wdata[31:0], mem_rdata[31:0]
//                                               Data_Memory pins

module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [9:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_wr,
    output logic        mem_rd,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [9:0]  addr_q;
    logic [31:0] wdata_q;
    logic [31:0] data_q;

    logic        sub_store_rej;
    logic        req_bad;
    logic [31:0] lane_word;
    logic [31:0] load_data;
    logic [31:0] merged;

`ifdef RMW_SUBWORD_EN
    assign sub_store_rej = 1'b0;
`else
    assign sub_store_rej = req_we && (req_size != SZ_WORD);
`endif

    assign req_bad = (req_size == SZ_RSVD) || is_misaligned(req_size, req_addr[1:0]) || sub_store_rej;

    // One lane block serves both paths: live memory data while reading,
    // the captured word while writing.
    assign lane_word = (state == ST_READ) ? mem_rdata : data_q;

    lsu_lane u_lane (
        .word      (lane_word),
        .lane      (addr_q[1:0]),
        .size      (size_q),
        .sign_ext  (signed_q),
        .wdata     (wdata_q),
        .load_data (load_data),
        .merged    (merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d   = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 32'h0;
        case (state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (req_bad)
                        state_d = ST_RESP;
                    else if (req_we && (req_size == SZ_WORD))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd   = 1'b1;
                mem_addr = addr_q[9:2];
                state_d  = we_q ? ST_WRITE : ST_RESP;
            end
            ST_WRITE: begin
                // A word store's mask covers all lanes, so merged == store data.
                mem_wr    = 1'b1;
                mem_addr  = addr_q[9:2];
                mem_wdata = merged;
                state_d   = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q      <= 1'b0;
            size_q    <= SZ_BYTE;
            signed_q  <= 1'b0;
            addr_q    <= 10'h0;
            wdata_q   <= 32'h0;
            data_q    <= 32'h0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        size_q    <= req_size;
                        signed_q  <= req_signed;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        rsp_rdata <= 32'h0;
                        rsp_err   <= req_bad;
                    end
                end
                ST_READ: begin
                    data_q <= mem_rdata;
                    if (!we_q)
                        rsp_rdata <= load_data;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit with a byte-array reference model

module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [9:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_wr, mem_rd;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    logic [31:0] mem [0:255];
    logic [7:0]  ref_b [0:1023];
    logic        do_init;
    logic [31:0] seed;
    int          n_pass = 0;
    int          n_total = 0;

    load_store_unit dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return seed ^ (32'(i) * 32'h9E37_79B1);
    endfunction

    // Data_Memory stand-in: synchronous write, combinational read.
    always @(posedge clk) begin
        if (do_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
        end else if (mem_wr) begin
            mem[mem_addr] <= mem_wdata;
        end
    end
    assign mem_rdata = mem_rd ? mem[mem_addr] : 32'h0;

    // Reference: memory as 1024 little-endian bytes; a request touches
    // 1, 2 or 4 consecutive bytes starting at its address.
    task automatic ref_model(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [9:0] a, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er, output int lat);
        int nb;
        logic [31:0] v;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
`ifndef RMW_SUBWORD_EN
        if (we && nb < 4) er = 1'b1;
`endif
        rd = 32'h0;
        if (er) begin
            lat = 1;
        end else if (we) begin
            for (int i = 0; i < nb; i++) ref_b[int'(a) + i] = wd[8*i +: 8];
            lat = (nb < 4) ? 3 : 2;
        end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) v = v | (32'(ref_b[int'(a) + i]) << (8*i));
            if (sg && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
            rd  = v;
            lat = 2;
        end
    endtask

    // Issues one request (unit must be idle) and observes it through the
    // handshake; cycle numbers count from 1 = first cycle after acceptance.
    task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                          input logic [9:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er, output int lat,
                          output int rd_cyc, output int wr_cyc,
                          output logic [7:0] wr_addr, output logic [31:0] wr_data,
                          output logic both);
        req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        rd = 32'h0; er = 1'b0; lat = 99; rd_cyc = 0; wr_cyc = 0;
        wr_addr = 8'h0; wr_data = 32'h0; both = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            if (mem_rd && mem_wr) both = 1'b1;
            if (mem_rd && rd_cyc == 0) rd_cyc = c;
            if (mem_wr && wr_cyc == 0) begin
                wr_cyc = c; wr_addr = mem_addr; wr_data = mem_wdata;
            end
            if (rsp_valid) begin
                lat = c; rd = rsp_rdata; er = rsp_err;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; do_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0;
        req_addr = 10'h0; req_wdata = 32'h0; rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            for (int k = 0; k < 4; k++) ref_b[4*i + k] = 8'(init_word(i) >> (8*k));
        @(posedge clk);
        @(negedge clk);
        do_init = 1'b0;
        n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready); else n_pass++;
        n_total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); else n_pass++;
        n_total++; if ({rsp_err, rsp_rdata} !== 33'h0) $display("FAIL reset_rsp got err=%b rdata=%h exp 0/0", rsp_err, rsp_rdata); else n_pass++;
        n_total++; if ({mem_wr, mem_rd, mem_addr, mem_wdata} !== 42'h0) $display("FAIL reset_mem_pins got wr=%b rd=%b addr=%h wdata=%h exp all 0", mem_wr, mem_rd, mem_addr, mem_wdata); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_word_store_load;
        logic [31:0] rd, wdat, erd; logic er, ee, both; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEAD_BEEF, erd, ee, el);
        do_req(1'b1, SZ_WORD, 1'b0, 10'h010, 32'hDEAD_BEEF, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (wc !== 1 || wa !== 8'h04 || wdat !== 32'hDEAD_BEEF) $display("FAIL word_store_write got cyc=%0d addr=%h data=%h exp 1/04/deadbeef", wc, wa, wdat); else n_pass++;
        n_total++; if (lat !== 2 || er !== 1'b0 || rd !== 32'h0 || rc !== 0) $display("FAIL word_store_rsp got lat=%0d err=%b rdata=%h rdcyc=%0d exp 2/0/0/0", lat, er, rd, rc); else n_pass++;
        ref_model(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== 32'hDEAD_BEEF || lat !== 2 || rc !== 1 || wc !== 0) $display("FAIL word_load got rdata=%h lat=%0d rdcyc=%0d wrcyc=%0d exp deadbeef/2/1/0", rd, lat, rc, wc); else n_pass++;
    endtask

    task automatic test_subword_load;
        logic [31:0] rd, wdat, erd; logic er, ee, both; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== 32'hFFFF_FFDE) $display("FAIL byte_load_signed got %h exp ffffffde", rd); else n_pass++;
        ref_model(1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_BYTE, 1'b0, 10'h013, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== 32'h0000_00DE) $display("FAIL byte_load_unsigned got %h exp 000000de", rd); else n_pass++;
        ref_model(1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_HALF, 1'b1, 10'h012, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== 32'hFFFF_DEAD || lat !== 2) $display("FAIL half_load_signed got %h lat=%0d exp ffffdead/2", rd, lat); else n_pass++;
    endtask

    task automatic test_subword_store;
        logic [31:0] rd, wdat, erd; logic er, ee, both; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b1, SZ_WORD, 1'b0, 10'h010, 32'h1122_3344, erd, ee, el);
        do_req(1'b1, SZ_WORD, 1'b0, 10'h010, 32'h1122_3344, rd, er, lat, rc, wc, wa, wdat, both);
        ref_model(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'hAABB_CC55, erd, ee, el);
        do_req(1'b1, SZ_BYTE, 1'b0, 10'h011, 32'hAABB_CC55, rd, er, lat, rc, wc, wa, wdat, both);
`ifdef RMW_SUBWORD_EN
        n_total++; if (rc !== 1 || wc !== 2 || lat !== 3 || er !== 1'b0) $display("FAIL byte_store_timing got rd=%0d wr=%0d lat=%0d err=%b exp 1/2/3/0", rc, wc, lat, er); else n_pass++;
        n_total++; if (wdat !== 32'h1122_5544 || wa !== 8'h04) $display("FAIL byte_store_merge got %h@%h exp 11225544@04", wdat, wa); else n_pass++;
`else
        n_total++; if (er !== 1'b1 || lat !== 1) $display("FAIL byte_store_reject got err=%b lat=%0d exp 1/1", er, lat); else n_pass++;
        n_total++; if (wc !== 0 || rc !== 0) $display("FAIL byte_store_no_access got wrcyc=%0d rdcyc=%0d exp 0/0", wc, rc); else n_pass++;
`endif
    endtask

    task automatic test_misaligned;
        logic [31:0] rd, wdat, erd; logic er, ee, both; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b0, SZ_HALF, 1'b0, 10'h011, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_HALF, 1'b0, 10'h011, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (er !== 1'b1 || lat !== 1 || rc !== 0 || rd !== 32'h0) $display("FAIL half_misaligned got err=%b lat=%0d rdcyc=%0d rdata=%h exp 1/1/0/0", er, lat, rc, rd); else n_pass++;
        ref_model(1'b0, SZ_WORD, 1'b0, 10'h012, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_WORD, 1'b0, 10'h012, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (er !== 1'b1 || lat !== 1 || rc !== 0) $display("FAIL word_misaligned got err=%b lat=%0d rdcyc=%0d exp 1/1/0", er, lat, rc); else n_pass++;
        ref_model(1'b1, SZ_RSVD, 1'b0, 10'h014, 32'h1234, erd, ee, el);
        do_req(1'b1, SZ_RSVD, 1'b0, 10'h014, 32'h1234, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (er !== 1'b1 || lat !== 1 || wc !== 0) $display("FAIL reserved_size got err=%b lat=%0d wrcyc=%0d exp 1/1/0", er, lat, wc); else n_pass++;
    endtask

    task automatic test_stall;
        logic [31:0] rd, wdat, erd, first; logic er, ee, both, stable; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b0, SZ_WORD, 1'b0, 10'h010, 32'h0, erd, ee, el);
        rsp_ready = 1'b0;
        req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 10'h010; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 0; c < 5 && !rsp_valid; c++) @(negedge clk);
        n_total++; if (rsp_valid !== 1'b1 || rsp_rdata !== erd) $display("FAIL stall_rsp got valid=%b rdata=%h exp 1/%h", rsp_valid, rsp_rdata, erd); else n_pass++;
        first = rsp_rdata;
        stable = 1'b1;
        req_we = 1'b0; req_size = SZ_BYTE; req_signed = 1'b1; req_addr = 10'h013; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== first || rsp_err !== 1'b0 || req_ready !== 1'b0 || mem_rd !== 1'b0) stable = 1'b0;
        end
        n_total++; if (stable !== 1'b1) $display("FAIL stall_hold got stable=%b exp 1", stable); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || mem_rd !== 1'b0) $display("FAIL stall_release got ready=%b valid=%b rd=%b exp 1/0/0", req_ready, rsp_valid, mem_rd); else n_pass++;
        ref_model(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, erd, ee, el);
        do_req(1'b0, SZ_BYTE, 1'b1, 10'h013, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== erd || lat !== 2) $display("FAIL stall_second_req got %h lat=%0d exp %h/2", rd, lat, erd); else n_pass++;
    endtask

    task automatic test_reset_mid_write;
        logic [31:0] rd, wdat, prior; logic er, ee, both; int lat, el, rc, wc; logic [7:0] wa;
        ref_model(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, prior, ee, el);
        req_we = 1'b1; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 10'h020;
        req_wdata = ~prior; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n_total++; if (mem_wr !== 1'b1) $display("FAIL rstmid_in_write got mem_wr=%b exp 1", mem_wr); else n_pass++;
        rst = 1'b1;
        #1;
        n_total++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0) $display("FAIL rstmid_drop got wr=%b rd=%b exp 0/0", mem_wr, mem_rd); else n_pass++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_total++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) $display("FAIL rstmid_idle got ready=%b valid=%b exp 1/0", req_ready, rsp_valid); else n_pass++;
        do_req(1'b0, SZ_WORD, 1'b0, 10'h020, 32'h0, rd, er, lat, rc, wc, wa, wdat, both);
        n_total++; if (rd !== prior) $display("FAIL rstmid_no_commit got %h exp %h", rd, prior); else n_pass++;
    endtask

    task automatic test_random;
        logic [31:0] rd, wdat, erd, wd; logic er, ee, both, we, sg; int lat, el, rc, wc, bad;
        logic [7:0] wa; logic [1:0] sz; logic [9:0] a;
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            sg = 1'($urandom_range(0, 1));
            a  = 10'($urandom_range(0, 127));
            if ($urandom_range(0, 3) != 0) begin
                if (sz == SZ_WORD) a[1:0] = 2'b00;
                if (sz == SZ_HALF) a[0] = 1'b0;
            end
            wd = $urandom;
            ref_model(we, sz, sg, a, wd, erd, ee, el);
            do_req(we, sz, sg, a, wd, rd, er, lat, rc, wc, wa, wdat, both);
            bad = 0;
            if (rd !== erd || er !== ee || lat !== el || both !== 1'b0) bad = 1;
            if ((rc != 0) !== (!ee && (!we || sz != SZ_WORD))) bad = 1;
            if ((wc != 0) !== (!ee && we)) bad = 1;
            n_total++;
            if (bad != 0)
                $display("FAIL random_%0d we=%b sz=%0d a=%h got rdata=%h err=%b lat=%0d rd=%0d wr=%0d both=%b exp rdata=%h err=%b lat=%0d",
                         n, we, sz, a, rd, er, lat, rc, wc, both, erd, ee, el);
            else n_pass++;
        end
    endtask

    task automatic test_memory_image;
        int bad;
        logic [31:0] w;
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            w = {ref_b[4*i+3], ref_b[4*i+2], ref_b[4*i+1], ref_b[4*i]};
            if (mem[i] !== w) bad++;
        end
        n_total++; if (bad != 0) $display("FAIL memory_image got %0d differing words exp 0", bad); else n_pass++;
    endtask

    initial begin
        seed = $urandom;
        test_reset;
        test_word_store_load;
        test_subword_load;
        test_subword_store;
        test_misaligned;
        test_stall;
        test_reset_mid_write;
        test_random;
        test_memory_image;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
